// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared encodings and scancode constants for the PS/2 key decoder
package ps2_key_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_E0    = 3'd1,
    ST_F0    = 3'd2,
    ST_E0F0  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  localparam logic [7:0] PFX_E0     = 8'hE0;
  localparam logic [7:0] PFX_F0     = 8'hF0;
  localparam logic [7:0] PFX_E1     = 8'hE1;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ECHO   = 8'hEE;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ERR0   = 8'h00;
  localparam logic [7:0] RSP_ERR1   = 8'hFF;

  // Pause is E1 plus seven trailing bytes; the event fires on the seventh.
  localparam logic [2:0] PAUSE_SKIP_LAST = 3'd6;

  localparam logic [2:0] KS_W     = 3'd0;
  localparam logic [2:0] KS_A     = 3'd1;
  localparam logic [2:0] KS_S     = 3'd2;
  localparam logic [2:0] KS_D     = 3'd3;
  localparam logic [2:0] KS_SPACE = 3'd4;
  localparam logic [2:0] KS_UP    = 3'd5;
  localparam logic [2:0] KS_LEFT  = 3'd6;
  localparam logic [2:0] KS_RIGHT = 3'd7;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_key_map.sv
// rtl/ps2_key_map.sv - maps scancode plus extended flag to a held-key bitmap index
module ps2_key_map
  import ps2_key_decoder_pkg::*;
(
  input  logic [7:0] code,
  input  logic       extended,
  output logic       hit,
  output logic [2:0] idx
);

  // Arrow keys share codes with the keypad, so the extended flag is part of the match.
  always_comb begin
    hit = 1'b1;
    idx = KS_W;
    if (!extended) begin
      case (code)
        SC_W:     idx = KS_W;
        SC_A:     idx = KS_A;
        SC_S:     idx = KS_S;
        SC_D:     idx = KS_D;
        SC_SPACE: idx = KS_SPACE;
        default:  hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    idx = KS_UP;
        SC_LEFT:  idx = KS_LEFT;
        SC_RIGHT: idx = KS_RIGHT;
        default:  hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 byte stream to key events and held-key bitmap
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic       key_repeat,
  output logic [7:0] key_state,
  output logic       kbd_ack,
  output logic       kbd_bat_ok,
  output logic       rx_err_pulse
);

  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 16) ? CNT_RAW : 16;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       key_state_q, key_state_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_extended_q, key_extended_d;
  logic             key_break_q, key_break_d;
  logic             key_repeat_q, key_repeat_d;
  logic             kbd_ack_q, kbd_ack_d;
  logic             kbd_bat_ok_q, kbd_bat_ok_d;
  logic             rx_err_pulse_q, rx_err_pulse_d;

  logic       accept;
  logic       ev_fire;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       clr_keys;
  logic       map_hit;
  logic [2:0] map_idx;

  assign accept     = rx_valid & ~rx_valid_q;
  assign rx_valid_d = rx_valid;

  ps2_key_map u_key_map (
    .code     (ev_code),
    .extended (ev_ext),
    .hit      (map_hit),
    .idx      (map_idx)
  );

  // Sequence tracking: decides which accepted byte completes an event.
  always_comb begin
    state_d        = state_q;
    skip_d         = skip_q;
    idle_cnt_d     = (idle_cnt_q == TIMEOUT_VAL) ? idle_cnt_q : idle_cnt_q + 1'b1;
    ev_fire        = 1'b0;
    ev_code        = rx_data;
    ev_ext         = 1'b0;
    ev_brk         = 1'b0;
    clr_keys       = 1'b0;
    kbd_ack_d      = 1'b0;
    kbd_bat_ok_d   = 1'b0;
    rx_err_pulse_d = 1'b0;
    if (accept) begin
      idle_cnt_d = '0;
      if (rx_error) begin
        rx_err_pulse_d = 1'b1;
        state_d        = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            case (rx_data)
              PFX_E0: state_d = ST_E0;
              PFX_F0: state_d = ST_F0;
              PFX_E1: begin
                state_d = ST_PAUSE;
                skip_d  = '0;
              end
              RSP_ACK: kbd_ack_d = 1'b1;
              RSP_BAT: begin
                kbd_bat_ok_d = 1'b1;
                clr_keys     = 1'b1;
              end
              RSP_ECHO, RSP_RESEND, RSP_ERR0, RSP_ERR1: begin
              end
              default: ev_fire = 1'b1;
            endcase
          end
          ST_E0: begin
            if (rx_data == PFX_F0) begin
              state_d = ST_E0F0;
            end else if (rx_data == PFX_E0) begin
              state_d = ST_IDLE;
            end else begin
              ev_fire = 1'b1;
              ev_ext  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_F0: begin
            ev_fire = 1'b1;
            ev_brk  = 1'b1;
            state_d = ST_IDLE;
          end
          ST_E0F0: begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
            state_d = ST_IDLE;
          end
          ST_PAUSE: begin
            if (skip_q == PAUSE_SKIP_LAST) begin
              ev_fire = 1'b1;
              ev_code = PFX_E1;
              state_d = ST_IDLE;
            end else begin
              skip_d = skip_q + 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if ((idle_cnt_q == TIMEOUT_VAL) && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Event fields hold between events; the bitmap follows mapped makes and breaks.
  always_comb begin
    key_valid_d    = 1'b0;
    key_code_d     = key_code_q;
    key_extended_d = key_extended_q;
    key_break_d    = key_break_q;
    key_repeat_d   = key_repeat_q;
    key_state_d    = clr_keys ? 8'h00 : key_state_q;
    if (ev_fire) begin
      key_valid_d    = 1'b1;
      key_code_d     = ev_code;
      key_extended_d = ev_ext;
      key_break_d    = ev_brk;
      key_repeat_d   = 1'b0;
      if (map_hit) begin
        if (ev_brk) begin
          key_state_d[map_idx] = 1'b0;
        end else begin
          key_repeat_d         = key_state_q[map_idx];
          key_state_d[map_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      skip_q         <= '0;
      idle_cnt_q     <= '0;
      rx_valid_q     <= 1'b0;
      key_state_q    <= '0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_extended_q <= 1'b0;
      key_break_q    <= 1'b0;
      key_repeat_q   <= 1'b0;
      kbd_ack_q      <= 1'b0;
      kbd_bat_ok_q   <= 1'b0;
      rx_err_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      skip_q         <= skip_d;
      idle_cnt_q     <= idle_cnt_d;
      rx_valid_q     <= rx_valid_d;
      key_state_q    <= key_state_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      key_extended_q <= key_extended_d;
      key_break_q    <= key_break_d;
      key_repeat_q   <= key_repeat_d;
      kbd_ack_q      <= kbd_ack_d;
      kbd_bat_ok_q   <= kbd_bat_ok_d;
      rx_err_pulse_q <= rx_err_pulse_d;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_extended_q;
  assign key_break    = key_break_q;
  assign key_repeat   = key_repeat_q;
  assign key_state    = key_state_q;
  assign kbd_ack      = kbd_ack_q;
  assign kbd_bat_ok   = kbd_bat_ok_q;
  assign rx_err_pulse = rx_err_pulse_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 200000, idle cycles after which a partial prefix sequence is abandoned (2 ms at 100 MHz).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: rx_data  input  8  received byte from the upstream PS/2 transmitter.
REQ-005 SHALL have port: rx_valid  input  1  upstream byte-valid level; may stay high more than one cycle per byte.
REQ-006 SHALL have port: rx_error  input  1  upstream parity error for the current byte.
REQ-007 SHALL have port: key_valid  output  1  one-cycle pulse: key event on key_* outputs.
REQ-008 SHALL have port: key_code  output  8  scancode of the event; 8'hE1 for Pause.
REQ-009 SHALL have port: key_extended  output  1  event was E0-prefixed.
REQ-010 SHALL have port: key_break  output  1  event is a release (F0-prefixed).
REQ-011 SHALL have port: key_repeat  output  1  make for a mapped key already held (typematic).
REQ-012 SHALL have port: key_state  output  8  held-key bitmap: [0]W 1D, [1]A 1C, [2]S 1B, [3]D 23, [4]Space 29, [5]Up E0 75, [6]Left E0 6B, [7]Right E0 74.
REQ-013 SHALL have port: kbd_ack  output  1  one-cycle pulse on 8'hFA received in IDLE.
REQ-014 SHALL have port: kbd_bat_ok  output  1  one-cycle pulse on 8'hAA received in IDLE.
REQ-015 SHALL have port: rx_err_pulse  output  1  one-cycle pulse when a byte with rx_error=1 is accepted.

Function
REQ-016 SHALL accept a byte only on a rising edge of rx_valid (registered rx_valid previously 0, now 1); sustained high level accepts once.
REQ-017 SHALL drive all pulse outputs and the key_* fields registered, exactly one cycle after the acceptance edge; key_code/key_extended/key_break/key_repeat hold until the next event.
REQ-018 SHALL implement states IDLE, E0, F0, E0F0, PAUSE.
REQ-019 IDLE: E0 -> E0; F0 -> F0; E1 -> PAUSE (skip count 0); FA -> kbd_ack; AA -> kbd_bat_ok and key_state cleared; EE, FE, 00, FF -> discarded; other byte -> make event, stay IDLE.
REQ-020 E0: F0 -> E0F0; E0 or F0 sequences otherwise invalid -> discard, IDLE; other byte -> extended make event, IDLE.
REQ-021 F0: any byte -> break event (extended=0), IDLE. E0F0: any byte -> break event (extended=1), IDLE.
REQ-022 PAUSE: discard next 7 bytes, then emit make event key_code=E1, extended=0, break=0, and return to IDLE.
REQ-023 Make on a mapped key SHALL set its key_state bit the cycle key_valid asserts; key_repeat=1 iff that bit was already 1; break SHALL clear it; unmapped keys leave key_state unchanged, key_repeat=0.
REQ-024 Accepted byte with rx_error=1 SHALL be discarded, pulse rx_err_pulse, force IDLE, and leave key_state unchanged.
REQ-025 A 16-bit-or-wider idle counter SHALL clear on each accepted byte, saturate at TIMEOUT_CYCLES, and on reaching it in any non-IDLE state force IDLE with no event.
REQ-026 Mapping match SHALL require both code and extended flag (e.g. 75 without E0 is keypad 8, unmapped).

Reset
REQ-027 rstn=0 at a clock edge SHALL force state IDLE, key_state=0, all pulse outputs 0, key_code=0, flags 0, idle counter 0, rx_valid history 0, within that edge, including mid-sequence.
REQ-028 A byte whose rx_valid rising edge coincides with reset SHALL be dropped.

Structure
REQ-029 Shared package SHALL hold state encoding, prefix constants (E0, F0, E1, FA, AA, EE, FE), key_state bit indices and mapped scancodes.
REQ-030 Sub-module ps2_key_map (combinational: code+extended -> hit, bit index) SHALL be instantiated once.

Verification
REQ-031 Bytes 1D held valid 3 cycles -> single key_valid, code 1D, key_state=0x01; repeat 1D -> key_repeat=1.
REQ-032 E0 F0 74 after E0 74 -> extended break, key_state[7] 1 then 0.
REQ-033 E1 14 77 E1 F0 14 F0 77 -> exactly one key_valid, code E1, key_state unchanged.
REQ-034 F0 then TIMEOUT_CYCLES idle, then 1C -> make A (break=0), key_state[1]=1.
REQ-035 E0 then byte 6B with rx_error=1 -> rx_err_pulse, no key_valid, state IDLE; next 29 -> make Space.
REQ-036 key_state=0xFF then AA -> kbd_bat_ok, key_state=0x00; rstn low during E0F0 -> next 23 is make D.
